// File: rtl/shipgunner_grid_pkg.sv
// Shared types for the battleship artillery unit: FSM states, LED result codes
// and the row/column to flat cell index mapping.
package shipgunner_grid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LED_NONE   = 2'd0,
    LED_MISS   = 2'd1,
    LED_HIT    = 2'd2,
    LED_REJECT = 2'd3
  } led_t;

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/shipgunner_edge.sv
// Rising-edge detector for the debounced fire button; a held button yields one pulse.
module shipgunner_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_btn,
  output logic o_press
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_prev <= 1'b0;
    else                r_prev <= i_btn;
  end

  assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/shipgunner_grid.sv
// Artillery unit: decodes a target cell per fire press, scores it against the ship map,
// keeps shot/hit history and counters, drives the result LEDs and declares WIN/LOSE.
module shipgunner_grid
  import shipgunner_grid_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int ROW_W      = 3,
  parameter int COL_W      = 3,
  parameter int SHIP_CELLS = 9,
  parameter int MAX_SHOTS  = 15,
  parameter int CNT_W      = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 NCH0,
  input  logic                 BTNIPT,
  input  logic [ROW_W-1:0]     ROWSEL,
  input  logic [COL_W-1:0]     COLSEL,
  input  logic [ROWS*COLS-1:0] SHIPMAP,
  output logic [ROWS*COLS-1:0] SHOTMAP,
  output logic [ROWS*COLS-1:0] HITMAP,
  output logic [CNT_W-1:0]     SHOTCNT,
  output logic [CNT_W-1:0]     HITCNT,
  output logic                 OUT,
  output logic                 RLED,
  output logic                 GLED,
  output logic                 BLED,
  output logic                 WIN,
  output logic                 LOSE
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  logic             w_press;
  state_t           r_state, w_nextState;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [CELLS-1:0] r_shotMap, w_shotMap, r_hitMap, w_hitMap;
  logic [CNT_W-1:0] r_shotCnt, w_shotCnt, r_hitCnt, w_hitCnt;
  logic             r_out, w_out, r_win, w_win, r_lose, w_lose;
  led_t             r_led, w_led;
  logic             w_oob, w_repeat, w_ship;
  logic [IDX_W-1:0] w_idx;
  logic [CELLS-1:0] w_mask;

  shipgunner_edge u_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (NCH0),
    .i_btn  (BTNIPT),
    .o_press(w_press)
  );

  always_ff @(posedge CLK) begin
    if (RST || NCH0) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_shotMap <= '0;
      r_hitMap  <= '0;
      r_shotCnt <= '0;
      r_hitCnt  <= '0;
      r_out     <= 1'b0;
      r_led     <= LED_NONE;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      if (r_state == ST_IDLE && w_press) begin
        r_row <= ROWSEL;
        r_col <= COLSEL;
      end
      r_shotMap <= w_shotMap;
      r_hitMap  <= w_hitMap;
      r_shotCnt <= w_shotCnt;
      r_hitCnt  <= w_hitCnt;
      r_out     <= w_out;
      r_led     <= w_led;
      r_win     <= w_win;
      r_lose    <= w_lose;
    end
  end

  // Out-of-range targets get an all-zero mask so they can never touch the maps.
  always_comb begin
    w_oob    = (int'(r_row) >= ROWS) || (int'(r_col) >= COLS);
    w_idx    = IDX_W'(cell_idx(int'(r_row), int'(r_col), COLS));
    w_mask   = w_oob ? '0 : (CELLS'(1) << w_idx);
    w_repeat = |(r_shotMap & w_mask);
    w_ship   = |(SHIPMAP & w_mask);
  end

  always_comb begin
    w_nextState = r_state;
    w_shotMap   = r_shotMap;
    w_hitMap    = r_hitMap;
    w_shotCnt   = r_shotCnt;
    w_hitCnt    = r_hitCnt;
    w_out       = 1'b0;
    w_led       = r_led;
    w_win       = r_win;
    w_lose      = r_lose;
    case (r_state)
      ST_IDLE: begin
        if (w_press) w_nextState = ST_EVAL;
      end
      ST_EVAL: begin
        w_nextState = ST_IDLE;
        if (w_oob || w_repeat) begin
          w_led = LED_REJECT;
        end else begin
          w_shotMap = r_shotMap | w_mask;
          if (r_shotCnt < CNT_W'(MAX_SHOTS)) w_shotCnt = r_shotCnt + 1'b1;
          if (w_ship) begin
            w_hitMap = r_hitMap | w_mask;
            if (r_hitCnt < CNT_W'(SHIP_CELLS)) w_hitCnt = r_hitCnt + 1'b1;
            w_led = LED_HIT;
            w_out = 1'b1;
          end else begin
            w_led = LED_MISS;
          end
          // A winning final shot at the shot limit counts as WIN, not LOSE.
          w_win  = (w_hitCnt == CNT_W'(SHIP_CELLS));
          w_lose = !w_win && (w_shotCnt == CNT_W'(MAX_SHOTS));
          if (w_win || w_lose) w_nextState = ST_OVER;
        end
      end
      ST_OVER: begin
        if (w_press) w_led = LED_REJECT;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign SHOTMAP = r_shotMap;
  assign HITMAP  = r_hitMap;
  assign SHOTCNT = r_shotCnt;
  assign HITCNT  = r_hitCnt;
  assign OUT     = r_out;
  assign RLED    = (r_led == LED_MISS);
  assign GLED    = (r_led == LED_HIT);
  assign BLED    = (r_led == LED_REJECT);
  assign WIN     = r_win;
  assign LOSE    = r_lose;

endmodule

// File: tb/tb_shipgunner_grid.sv
// Directed self-checking bench for shipgunner_grid with a fixed nine-cell fleet.
module tb_shipgunner_grid;

  localparam int ROW_W = 3;
  localparam int COL_W = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        NCH0 = 1'b0;
  logic        BTNIPT = 1'b0;
  logic [2:0]  ROWSEL = '0;
  logic [2:0]  COLSEL = '0;
  logic [24:0] SHIPMAP = 25'h100AAAA;
  logic [24:0] SHOTMAP, HITMAP;
  logic [4:0]  SHOTCNT, HITCNT;
  logic        OUT, RLED, GLED, BLED, WIN, LOSE;

  int checks = 0;
  int errors = 0;

  // Fleet cells 1,3,5,7,9,11,13,15,24 as (row,col)
  int shipR[9] = '{0, 0, 1, 1, 1, 2, 2, 3, 4};
  int shipC[9] = '{1, 3, 0, 2, 4, 1, 3, 0, 4};
  // First fifteen empty cells 0,2,4,...,14,16..22
  int waterIdx[15] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 17, 18, 19, 20, 21, 22};

  shipgunner_grid dut (
    .CLK(CLK), .RST(RST), .NCH0(NCH0), .BTNIPT(BTNIPT),
    .ROWSEL(ROWSEL), .COLSEL(COLSEL), .SHIPMAP(SHIPMAP),
    .SHOTMAP(SHOTMAP), .HITMAP(HITMAP), .SHOTCNT(SHOTCNT), .HITCNT(HITCNT),
    .OUT(OUT), .RLED(RLED), .GLED(GLED), .BLED(BLED), .WIN(WIN), .LOSE(LOSE)
  );

  always #5 CLK = ~CLK;

  task automatic doReset();
    @(negedge CLK); RST = 1'b1; BTNIPT = 1'b0;
    @(negedge CLK); RST = 1'b0;
  endtask

  // Press at one negedge, release at the next; returns at the negedge where results are visible.
  task automatic fire(input int r, input int c);
    @(negedge CLK);
    ROWSEL = ROW_W'(r);
    COLSEL = COL_W'(c);
    BTNIPT = 1'b1;
    @(negedge CLK); BTNIPT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    fire(1, 2);
    fire(0, 0);
    @(negedge CLK); BTNIPT = 1'b1; ROWSEL = 3'd2; COLSEL = 3'd2;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; BTNIPT = 1'b0;
    checks++;
    if ({SHOTMAP, HITMAP} !== 50'd0) begin errors++; $display("[TB] FAIL reset_maps: got %h/%h want 0/0", SHOTMAP, HITMAP); end
    checks++;
    if ({SHOTCNT, HITCNT} !== 10'd0) begin errors++; $display("[TB] FAIL reset_cnts: got %0d/%0d want 0/0", SHOTCNT, HITCNT); end
    checks++;
    if ({OUT, RLED, GLED, BLED, WIN, LOSE} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000000", {OUT, RLED, GLED, BLED, WIN, LOSE}); end
  endtask

  task automatic test_hit();
    doReset();
    @(negedge CLK); ROWSEL = 3'd1; COLSEL = 3'd2; BTNIPT = 1'b1;
    @(negedge CLK); BTNIPT = 1'b0;
    checks++;
    if ({OUT, GLED, SHOTCNT} !== {1'b0, 1'b0, 5'd0}) begin errors++; $display("[TB] FAIL hit_early: got out=%b gled=%b shots=%0d want 0 0 0", OUT, GLED, SHOTCNT); end
    @(negedge CLK);
    checks++;
    if ({OUT, GLED, RLED, BLED} !== 4'b1100) begin errors++; $display("[TB] FAIL hit_leds: got out/g/r/b=%b want 1100", {OUT, GLED, RLED, BLED}); end
    checks++;
    if ({SHOTCNT, HITCNT} !== {5'd1, 5'd1}) begin errors++; $display("[TB] FAIL hit_cnts: got %0d/%0d want 1/1", SHOTCNT, HITCNT); end
    checks++;
    if ({SHOTMAP, HITMAP} !== {25'h80, 25'h80}) begin errors++; $display("[TB] FAIL hit_maps: got %h/%h want 80/80", SHOTMAP, HITMAP); end
    @(negedge CLK);
    checks++;
    if ({OUT, GLED} !== 2'b01) begin errors++; $display("[TB] FAIL hit_pulse: got out/gled=%b want 01", {OUT, GLED}); end
  endtask

  task automatic test_miss_repeat();
    doReset();
    fire(0, 0);
    checks++;
    if ({RLED, GLED, BLED, OUT} !== 4'b1000) begin errors++; $display("[TB] FAIL miss_leds: got r/g/b/out=%b want 1000", {RLED, GLED, BLED, OUT}); end
    checks++;
    if ({SHOTCNT, HITCNT, SHOTMAP} !== {5'd1, 5'd0, 25'h1}) begin errors++; $display("[TB] FAIL miss_state: got %0d/%0d/%h want 1/0/1", SHOTCNT, HITCNT, SHOTMAP); end
    fire(0, 0);
    checks++;
    if ({RLED, GLED, BLED} !== 3'b001) begin errors++; $display("[TB] FAIL repeat_leds: got r/g/b=%b want 001", {RLED, GLED, BLED}); end
    checks++;
    if ({SHOTCNT, SHOTMAP} !== {5'd1, 25'h1}) begin errors++; $display("[TB] FAIL repeat_state: got %0d/%h want 1/1", SHOTCNT, SHOTMAP); end
  endtask

  task automatic test_out_of_range();
    doReset();
    fire(6, 0);
    checks++;
    if ({RLED, GLED, BLED} !== 3'b001) begin errors++; $display("[TB] FAIL oob_row_leds: got r/g/b=%b want 001", {RLED, GLED, BLED}); end
    checks++;
    if ({SHOTMAP, HITMAP, SHOTCNT} !== 55'd0) begin errors++; $display("[TB] FAIL oob_row_state: got %h/%h/%0d want 0/0/0", SHOTMAP, HITMAP, SHOTCNT); end
    fire(0, 5);
    checks++;
    if ({BLED, SHOTMAP, SHOTCNT} !== {1'b1, 25'h0, 5'd0}) begin errors++; $display("[TB] FAIL oob_col: got bled=%b map=%h shots=%0d want 1 0 0", BLED, SHOTMAP, SHOTCNT); end
    @(negedge CLK); ROWSEL = 3'd0; COLSEL = 3'd0; BTNIPT = 1'b1;
    repeat (20) @(negedge CLK);
    BTNIPT = 1'b0;
    @(negedge CLK);
    checks++;
    if ({SHOTCNT, SHOTMAP, RLED, BLED} !== {5'd1, 25'h1, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL hold_once: got shots=%0d map=%h r=%b b=%b want 1 1 1 0", SHOTCNT, SHOTMAP, RLED, BLED); end
  endtask

  task automatic test_win();
    doReset();
    for (int i = 0; i < 8; i++) fire(shipR[i], shipC[i]);
    checks++;
    if ({WIN, LOSE, HITCNT} !== {1'b0, 1'b0, 5'd8}) begin errors++; $display("[TB] FAIL win_early: got win=%b lose=%b hits=%0d want 0 0 8", WIN, LOSE, HITCNT); end
    fire(shipR[8], shipC[8]);
    checks++;
    if ({WIN, LOSE, GLED, HITCNT, SHOTCNT} !== {3'b101, 5'd9, 5'd9}) begin errors++; $display("[TB] FAIL win_set: got w/l/g=%b hits=%0d shots=%0d want 101 9 9", {WIN, LOSE, GLED}, HITCNT, SHOTCNT); end
    checks++;
    if ({SHOTMAP, HITMAP} !== {25'h100AAAA, 25'h100AAAA}) begin errors++; $display("[TB] FAIL win_maps: got %h/%h want 100aaaa/100aaaa", SHOTMAP, HITMAP); end
    fire(0, 0);
    checks++;
    if ({BLED, RLED, GLED, WIN} !== 4'b1001) begin errors++; $display("[TB] FAIL win_over_leds: got b/r/g/win=%b want 1001", {BLED, RLED, GLED, WIN}); end
    checks++;
    if ({SHOTCNT, HITCNT, SHOTMAP} !== {5'd9, 5'd9, 25'h100AAAA}) begin errors++; $display("[TB] FAIL win_frozen: got %0d/%0d/%h want 9/9/100aaaa", SHOTCNT, HITCNT, SHOTMAP); end
  endtask

  task automatic test_win_at_max();
    doReset();
    for (int i = 0; i < 6; i++) fire(waterIdx[i] / 5, waterIdx[i] % 5);
    for (int i = 0; i < 9; i++) fire(shipR[i], shipC[i]);
    checks++;
    if ({WIN, LOSE, SHOTCNT, HITCNT} !== {2'b10, 5'd15, 5'd9}) begin errors++; $display("[TB] FAIL win_at_max: got win/lose=%b shots=%0d hits=%0d want 10 15 9", {WIN, LOSE}, SHOTCNT, HITCNT); end
  endtask

  task automatic test_lose_nch0();
    doReset();
    for (int i = 0; i < 14; i++) fire(waterIdx[i] / 5, waterIdx[i] % 5);
    checks++;
    if ({LOSE, SHOTCNT} !== {1'b0, 5'd14}) begin errors++; $display("[TB] FAIL lose_early: got lose=%b shots=%0d want 0 14", LOSE, SHOTCNT); end
    fire(waterIdx[14] / 5, waterIdx[14] % 5);
    checks++;
    if ({LOSE, WIN, RLED, SHOTCNT, HITCNT} !== {3'b101, 5'd15, 5'd0}) begin errors++; $display("[TB] FAIL lose_set: got l/w/r=%b shots=%0d hits=%0d want 101 15 0", {LOSE, WIN, RLED}, SHOTCNT, HITCNT); end
    checks++;
    if ({SHOTMAP, HITMAP} !== {25'h07F5555, 25'h0}) begin errors++; $display("[TB] FAIL lose_maps: got %h/%h want 7f5555/0", SHOTMAP, HITMAP); end
    fire(4, 4);
    checks++;
    if ({BLED, LOSE, SHOTCNT, HITCNT} !== {2'b11, 5'd15, 5'd0}) begin errors++; $display("[TB] FAIL lose_over: got b/l=%b shots=%0d hits=%0d want 11 15 0", {BLED, LOSE}, SHOTCNT, HITCNT); end
    // NCH0 pulsed during the EVAL cycle of a legal hit must discard it entirely
    @(negedge CLK); NCH0 = 1'b1;
    @(negedge CLK); NCH0 = 1'b0;
    fire(0, 2);
    checks++;
    if ({SHOTCNT, RLED} !== {5'd1, 1'b1}) begin errors++; $display("[TB] FAIL nch0_clear_then_fire: got shots=%0d r=%b want 1 1", SHOTCNT, RLED); end
    @(negedge CLK); ROWSEL = 3'd1; COLSEL = 3'd2; BTNIPT = 1'b1;
    @(negedge CLK); BTNIPT = 1'b0; NCH0 = 1'b1;
    @(negedge CLK); NCH0 = 1'b0;
    checks++;
    if ({SHOTMAP, HITMAP, SHOTCNT, HITCNT} !== 60'd0) begin errors++; $display("[TB] FAIL nch0_eval_abort: got %h/%h/%0d/%0d want 0/0/0/0", SHOTMAP, HITMAP, SHOTCNT, HITCNT); end
    checks++;
    if ({OUT, RLED, GLED, BLED, WIN, LOSE} !== 6'b0) begin errors++; $display("[TB] FAIL nch0_flags: got %b want 000000", {OUT, RLED, GLED, BLED, WIN, LOSE}); end
    @(negedge CLK);
    checks++;
    if ({OUT, GLED, SHOTCNT} !== {1'b0, 1'b0, 5'd0}) begin errors++; $display("[TB] FAIL nch0_no_late_update: got out=%b g=%b shots=%0d want 0 0 0", OUT, GLED, SHOTCNT); end
    fire(1, 2);
    checks++;
    if ({GLED, SHOTCNT, HITCNT} !== {1'b1, 5'd1, 5'd1}) begin errors++; $display("[TB] FAIL nch0_idle_after: got g=%b shots=%0d hits=%0d want 1 1 1", GLED, SHOTCNT, HITCNT); end
  endtask

  initial begin
    doReset();
    test_reset();
    test_hit();
    test_miss_repeat();
    test_out_of_range();
    test_win();
    test_win_at_max();
    test_lose_nch0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
